// File: rtl/funct_decode_seq_pkg.sv
// Shared encodings for funct_decode_seq: funct fields, ALU op codes, HI/LO select, FSM states.
// FUNCT_DECODE_SEQ_DIV_EN adds the divide state.
package funct_decode_seq_pkg;

  localparam logic [5:0] FnSll     = 6'b000000;
  localparam logic [5:0] FnSrl     = 6'b000010;
  localparam logic [5:0] FnSra     = 6'b000011;
  localparam logic [5:0] FnJr      = 6'b001000;
  localparam logic [5:0] FnSyscall = 6'b001100;
  localparam logic [5:0] FnMfhi    = 6'b010000;
  localparam logic [5:0] FnMflo    = 6'b010010;
  localparam logic [5:0] FnMult    = 6'b011000;
  localparam logic [5:0] FnMultu   = 6'b011001;
  localparam logic [5:0] FnDiv     = 6'b011010;
  localparam logic [5:0] FnDivu    = 6'b011011;
  localparam logic [5:0] FnAdd     = 6'b100000;
  localparam logic [5:0] FnAddu    = 6'b100001;
  localparam logic [5:0] FnSub     = 6'b100010;
  localparam logic [5:0] FnSubu    = 6'b100011;
  localparam logic [5:0] FnAnd     = 6'b100100;
  localparam logic [5:0] FnOr      = 6'b100101;
  localparam logic [5:0] FnXor     = 6'b100110;
  localparam logic [5:0] FnNor     = 6'b100111;
  localparam logic [5:0] FnSlt     = 6'b101010;
  localparam logic [5:0] FnSltu    = 6'b101011;

  localparam logic [3:0] AluNone = 4'd0;
  localparam logic [3:0] AluAdd  = 4'd1;
  localparam logic [3:0] AluAddu = 4'd2;
  localparam logic [3:0] AluSub  = 4'd3;
  localparam logic [3:0] AluSubu = 4'd4;
  localparam logic [3:0] AluAnd  = 4'd5;
  localparam logic [3:0] AluOr   = 4'd6;
  localparam logic [3:0] AluXor  = 4'd7;
  localparam logic [3:0] AluNor  = 4'd8;
  localparam logic [3:0] AluSlt  = 4'd9;
  localparam logic [3:0] AluSltu = 4'd10;
  localparam logic [3:0] AluSll  = 4'd11;
  localparam logic [3:0] AluSrl  = 4'd12;
  localparam logic [3:0] AluSra  = 4'd13;

  localparam logic [1:0] HiloAlu = 2'b00;
  localparam logic [1:0] HiloHi  = 2'b01;
  localparam logic [1:0] HiloLo  = 2'b10;
  localparam logic [1:0] HiloIll = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StFix
`ifdef FUNCT_DECODE_SEQ_DIV_EN
    , StDiv
`endif
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// Divider logic exists only when FUNCT_DECODE_SEQ_DIV_EN is defined.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
`ifdef FUNCT_DECODE_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
`ifdef FUNCT_DECODE_SEQ_DIV_EN
  logic               div_q, div_d;
  logic               zero_q, zero_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   quot, rem;
`endif

  assign a_neg = is_signed & op_a[WIDTH-1];
  assign b_neg = is_signed & op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;
  assign last  = (cnt_q == CntW'(WIDTH - 1));

  // Low half starts as multiplier / dividend; high half accumulates product / remainder.
  always_comb begin
    acc_d     = acc_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dsr_q : '0)};
`ifdef FUNCT_DECODE_SEQ_DIV_EN
    div_d     = div_q;
    zero_d    = zero_q;
    neg_rem_d = neg_rem_q;
    shifted   = acc_q[2*WIDTH-1:WIDTH-1];
    diff      = shifted - {1'b0, dsr_q};
`endif
    if (start) begin
      acc_d     = {{WIDTH{1'b0}}, a_mag};
      dsr_d     = b_mag;
      cnt_d     = '0;
      neg_res_d = a_neg ^ b_neg;
`ifdef FUNCT_DECODE_SEQ_DIV_EN
      div_d     = is_div;
      zero_d    = (op_b == '0);
      neg_rem_d = a_neg;
`endif
    end else if (step) begin
      cnt_d = cnt_q + CntW'(1);
`ifdef FUNCT_DECODE_SEQ_DIV_EN
      if (div_q) begin
        if (shifted >= {1'b0, dsr_q}) begin
          acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
`else
      acc_d = {sum, acc_q[WIDTH-1:1]};
`endif
    end
  end

  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef FUNCT_DECODE_SEQ_DIV_EN
    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      // Divide by zero leaves |dividend| in rem, so sign restore gives the dividend back.
      res_lo = zero_q ? '1 : (neg_res_q ? -quot : quot);
      res_hi = neg_rem_q ? -rem : rem;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
`ifdef FUNCT_DECODE_SEQ_DIV_EN
      div_q     <= 1'b0;
      zero_q    <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      dsr_q     <= dsr_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
`ifdef FUNCT_DECODE_SEQ_DIV_EN
      div_q     <= div_d;
      zero_q    <= zero_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

endmodule

// File: rtl/funct_decode_seq.sv
// R-type funct decoder with a sequenced multiply (and optional divide) unit owning HI/LO.
// Define FUNCT_DECODE_SEQ_DIV_EN to enable DIV/DIVU.
module funct_decode_seq
  import funct_decode_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [OPW-1:0]   alu_op,
  output logic             is_jr,
  output logic             is_syscall,
  output logic             is_shamt,
  output logic [1:0]       hilo_sel,
  output logic             out_valid,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state_q, state_d;

  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             jr_q, jr_d, sys_q, sys_d, shamt_q, shamt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [3:0]       dec_alu;
  logic             dec_jr, dec_sys, dec_shamt, dec_mul, dec_signed;
  logic [1:0]       dec_sel;
`ifdef FUNCT_DECODE_SEQ_DIV_EN
  logic             dec_div;
`endif

  logic             md_start, md_step, md_last;
  logic [WIDTH-1:0] md_hi, md_lo;

  always_comb begin
    dec_alu    = AluNone;
    dec_jr     = 1'b0;
    dec_sys    = 1'b0;
    dec_shamt  = 1'b0;
    dec_sel    = HiloAlu;
    dec_mul    = 1'b0;
    dec_signed = 1'b0;
`ifdef FUNCT_DECODE_SEQ_DIV_EN
    dec_div    = 1'b0;
`endif
    case (funct)
      FnAdd:     dec_alu = AluAdd;
      FnAddu:    dec_alu = AluAddu;
      FnSub:     dec_alu = AluSub;
      FnSubu:    dec_alu = AluSubu;
      FnAnd:     dec_alu = AluAnd;
      FnOr:      dec_alu = AluOr;
      FnXor:     dec_alu = AluXor;
      FnNor:     dec_alu = AluNor;
      FnSlt:     dec_alu = AluSlt;
      FnSltu:    dec_alu = AluSltu;
      FnSll:     begin dec_alu = AluSll; dec_shamt = 1'b1; end
      FnSrl:     begin dec_alu = AluSrl; dec_shamt = 1'b1; end
      FnSra:     begin dec_alu = AluSra; dec_shamt = 1'b1; end
      FnJr:      dec_jr  = 1'b1;
      FnSyscall: dec_sys = 1'b1;
      FnMfhi:    dec_sel = HiloHi;
      FnMflo:    dec_sel = HiloLo;
      FnMult:    begin dec_mul = 1'b1; dec_signed = 1'b1; end
      FnMultu:   dec_mul = 1'b1;
`ifdef FUNCT_DECODE_SEQ_DIV_EN
      FnDiv:     begin dec_div = 1'b1; dec_signed = 1'b1; end
      FnDivu:    dec_div = 1'b1;
`endif
      default:   dec_sel = HiloIll;
    endcase
  end

  // Instructions are only taken in idle; anything presented while busy is dropped.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    md_start = 1'b0;
    valid_d  = 1'b0;
    alu_op_d = '0;
    jr_d     = 1'b0;
    sys_d    = 1'b0;
    shamt_d  = 1'b0;
    sel_d    = HiloAlu;
    case (state_q)
      StIdle: begin
        if (valid_in) begin
          valid_d  = 1'b1;
          alu_op_d = OPW'(dec_alu);
          jr_d     = dec_jr;
          sys_d    = dec_sys;
          shamt_d  = dec_shamt;
          sel_d    = dec_sel;
          if (dec_mul) begin
            md_start = 1'b1;
            state_d  = StMul;
          end
`ifdef FUNCT_DECODE_SEQ_DIV_EN
          else if (dec_div) begin
            md_start = 1'b1;
            state_d  = StDiv;
          end
`endif
        end
      end
      StMul: begin
        if (md_last) state_d = StFix;
      end
`ifdef FUNCT_DECODE_SEQ_DIV_EN
      StDiv: begin
        if (md_last) state_d = StFix;
      end
`endif
      StFix: begin
        hi_d    = md_hi;
        lo_d    = md_lo;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
`ifdef FUNCT_DECODE_SEQ_DIV_EN
    md_step = (state_q == StMul) || (state_q == StDiv);
`else
    md_step = (state_q == StMul);
`endif
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .step     (md_step),
`ifdef FUNCT_DECODE_SEQ_DIV_EN
    .is_div   (dec_div),
`endif
    .is_signed(dec_signed),
    .op_a     (rs_val),
    .op_b     (rt_val),
    .last     (md_last),
    .res_hi   (md_hi),
    .res_lo   (md_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      alu_op_q <= '0;
      jr_q     <= 1'b0;
      sys_q    <= 1'b0;
      shamt_q  <= 1'b0;
      sel_q    <= HiloAlu;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      alu_op_q <= alu_op_d;
      jr_q     <= jr_d;
      sys_q    <= sys_d;
      shamt_q  <= shamt_d;
      sel_q    <= sel_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign is_jr      = jr_q;
  assign is_syscall = sys_q;
  assign is_shamt   = shamt_q;
  assign hilo_sel   = sel_q;
  assign out_valid  = valid_q;
  assign stall      = (state_q != StIdle);
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: doc/funct_decode_seq.md
FUNCT_DECODE_SEQ -- requirements
Module: funct_decode_seq

Interface
REQ-001 Parameter WIDTH, default 32; datapath width of operands, HI and LO (minimum 8, even).
REQ-002 Parameter OPW, default 4; width of alu_op.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid_in  input  1  R-type instruction presented this cycle.
REQ-006 funct  input  6  instruction funct field.
REQ-007 rs_val, rt_val  input  WIDTH each  operand values for MULT/DIV.
REQ-008 alu_op  output  OPW  registered ALU operation code.
REQ-009 is_jr, is_syscall, is_shamt  output  1 each  registered class flags.
REQ-010 hilo_sel  output  2  registered: 00 ALU, 01 HI, 10 LO, 11 illegal funct.
REQ-011 out_valid  output  1  registered decode outputs valid this cycle.
REQ-012 stall  output  1  upstream holds instruction; valid_in is ignored while high.
REQ-013 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 Decode latency exactly 1 cycle: accepted valid_in at edge N gives out_valid plus decoded fields during cycle N+1.
REQ-015 ALU functs (ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA) map to package codes; is_shamt=1 only for SLL, SRL, SRA.
REQ-016 JR sets is_jr; SYSCALL sets is_syscall; MFHI/MFLO set hilo_sel 01/10; unlisted funct gives hilo_sel=11, alu_op=0, all flags 0.
REQ-017 State machine IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-018 IDLE: accepted MULT/MULTU -> MUL; DIV/DIVU -> DIV; operands latched, signed forms latch magnitudes and result sign.
REQ-019 MUL and DIV: one shift-add / restoring-subtract step per cycle, WIDTH cycles, then FIX.
REQ-020 FIX: one cycle applying two's-complement sign correction (signed ops), write HI/LO, return to IDLE.
REQ-021 MULT: {hi,lo}=2*WIDTH-bit product; DIV: lo=quotient, hi=remainder, remainder sign follows dividend.
REQ-022 Divide by zero: lo=all ones, hi=dividend unmodified; same WIDTH+1 cycle timing.
REQ-023 stall high from cycle after MUL/DIV acceptance through FIX cycle inclusive; low in IDLE.
REQ-024 MULT/DIV op itself produces out_valid=1, hilo_sel=00, alu_op=0 in cycle N+1.
REQ-025 Busy engine: valid_in ignored, out_valid=0; upstream re-presents after stall falls.
REQ-026 MFHI/MFLO accepted only in IDLE, so they always observe completed HI/LO.
REQ-027 hi/lo change only in FIX cycle; total MUL/DIV occupancy WIDTH+1 cycles after acceptance.

Reset
REQ-028 rst at any edge, mid-operation included: state IDLE, stall=0, out_valid=0, alu_op=0, all flags 0, hilo_sel=00, hi=0, lo=0; in-flight op discarded.
REQ-029 rst has priority over valid_in in the same cycle.

Configuration
REQ-030 Macro FUNCT_DECODE_SEQ_DIV_EN defined: DIV/DIVU supported per REQ-018..022.
REQ-031 Macro undefined: DIV state and divider logic absent; DIV/DIVU decode as illegal (hilo_sel=11), no stall, hi/lo unchanged.

Structure
REQ-032 Shared package holds funct encodings, alu_op code constants, hilo_sel constants, and FSM state enum.
REQ-033 One sub-module muldiv_iter contains the iterative multiply/divide datapath and step counter; funct_decode_seq holds decode registers and FSM.

Verification
REQ-034 rst then funct=100000 valid_in=1 -> next cycle out_valid=1, alu_op=ADD code, stall=0.
REQ-035 WIDTH=32, MULT rs=-3 rt=7 -> stall for 33 cycles, then hi=FFFFFFFF, lo=FFFFFFEB.
REQ-036 DIVU rs=100 rt=7 -> lo=14, hi=2 after 33 cycles; DIV rs=-7 rt=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-037 DIV rs=5 rt=0 -> lo=FFFFFFFF, hi=5; then MFHI -> hilo_sel=01.
REQ-038 ADD issued during busy MULT -> no out_valid until stall falls; rst at cycle 10 of MULT -> hi=lo=0, stall=0 next cycle.
REQ-039 Build without FUNCT_DECODE_SEQ_DIV_EN, DIV -> hilo_sel=11, stall never asserted.
